lcd_fb_ctrl: RTL and testbench
==============================

Name: lcd_fb_ctrl

Overview:
Write-side controller for the double-banked LCD frame buffer of one Game Boy core. It sequences PPU pixel strobes into a 2 x 160x144 buffer and generates the buffer's write address, data and enable. It also blanks the buffer when the LCD turns off, and hands completed banks to the scan-out side at display vsync, forcing the hand-off if the next frame starts first. It sits between the PPU pixel output and the frame-buffer dpram write port; scan-out reads the bank given by rd_bank.

Parameters:
WIDTH, 160, pixels per line
HEIGHT, 144, lines per frame
NPIX, WIDTH*HEIGHT (23040), pixels per bank; bank 1 base = NPIX
AW, 16, write address width (must hold 2*NPIX-1)
BLANK_COLOR, 15'h7FFF, BGR555 value written during clear

Ports:
clk  in  1  system clock (PPU clock domain)
reset  in  1  synchronous, active-high reset
lcd_on  in  1  LCDC enable from PPU
lcd_mode  in  2  PPU STAT mode (0 hblank, 1 vblank, 2 oam, 3 transfer)
pix_valid  in  1  one-cycle pixel strobe
pix_data  in  15  BGR555 pixel
disp_vsync  in  1  one-cycle pulse, scan-out frame start (already synced to clk)
wr_en  out  1  frame-buffer write enable
wr_addr  out  AW  frame-buffer write address
wr_data  out  15  frame-buffer write data
rd_bank  out  1  bank scan-out must read
frame_done  out  1  one-cycle pulse, complete frame captured
tear_cnt  out  8  forced-swap counter, saturating
ovf  out  1  sticky, pixel strobe arrived with ptr==NPIX

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high.
- State: ptr[14:0], wr_bank, pending, FSM {CLEAR, OFF, ACTIVE, VBLANK}.
- Reset: FSM=CLEAR, ptr=0, wr_bank=0, rd_bank=1, pending=0, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, tear_cnt=0, ovf=0.
- Write outputs are registered. A write accepted in cycle N appears on wr_en/wr_addr/wr_data in cycle N+1. wr_addr = ptr + (wr_bank ? NPIX : 0).
- CLEAR:
  - Each cycle: wr_en=1, wr_data=BLANK_COLOR, ptr++.
  - When ptr==NPIX-1 is written: rd_bank<=wr_bank, wr_bank<=~wr_bank, pending<=0, ptr<=0. Next state is ACTIVE if lcd_on, else OFF.
  - pix_valid and lcd_on edges are ignored until the clear completes. The clear always runs to completion.
- OFF: no writes. lcd_on=1 -> ACTIVE with ptr=0.
- ACTIVE:
  - pix_valid with ptr<NPIX: write pix_data, ptr++.
  - pix_valid with ptr==NPIX: no write, ovf<=1.
  - lcd_mode==1 -> VBLANK and ptr<=0. If the pixel count, including any same-cycle pixel, equals NPIX: frame_done pulse, pending<=1. Otherwise the short frame is discarded (no pending).
- VBLANK: pix_valid is ignored. lcd_mode!=1 -> ACTIVE.
- lcd_on=0 in ACTIVE or VBLANK -> CLEAR with ptr=0 on the next cycle. This discards the partial frame; pending is kept until the clear's swap.
- Swap rules (ACTIVE/VBLANK only):
  - disp_vsync && pending: rd_bank<=wr_bank, wr_bank<=~wr_bank, pending<=0.
  - Forced swap: pending and the first pixel (ptr==0 && pix_valid) arrive before disp_vsync. Swap in the same cycle; tear_cnt++ (saturates at 255). That pixel is written to the NEW wr_bank at address offset 0.
  - disp_vsync and forced condition in the same cycle: exactly one swap, tear_cnt unchanged.
- disp_vsync without pending: no effect.
- Invariant: outside reset, wr_bank != rd_bank always holds after the first clear.
- ovf is cleared only by reset.

Test Plan:
- Reset, lcd_on=1: 23040 writes of 7FFF at addresses 0..22999+40 (0..0x59FF). Then rd_bank=0, wr_bank=1, state ACTIVE.
- 23040 pixels (data=index&7FFF), then mode=1: writes at 0x5A00..0xB3FF with 1-cycle latency, frame_done pulses once. disp_vsync -> rd_bank=1, later writes start at 0.
- 100 pixels, then mode=1: no frame_done, pending=0, next frame restarts at offset 0 of the same bank.
- Complete frame, no disp_vsync, next frame's first pixel: same-cycle swap, first write to the other bank at offset 0, tear_cnt=1. Repeat 300 times -> tear_cnt=255.
- lcd_on drops at pixel 5000: CLEAR writes 23040 x 7FFF into the current wr_bank, swap, state OFF; pix_valid during clear produces no writes.
- 23041st pixel before mode=1: no write, ovf=1. Frame still completes on mode=1 (count==NPIX).

Source files
------------

// File: rtl/lcd_fb_if.sv
// rtl/lcd_fb_if.sv - pixel input and frame-buffer write port bundle
interface lcd_fb_if #(
    parameter int AW = 16
);
    logic          pix_valid;
    logic [14:0]   pix_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [14:0]   wr_data;

    // master is the write controller: consumes pixels, drives the buffer write port
    modport master (
        input  pix_valid, pix_data,
        output wr_en, wr_addr, wr_data
    );
    modport slave (
        output pix_valid, pix_data,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/lcd_fb_ctrl.sv
// rtl/lcd_fb_ctrl.sv - write-side controller for a double-banked LCD frame buffer
module lcd_fb_ctrl #(
    parameter int          WIDTH       = 160,
    parameter int          HEIGHT      = 144,
    parameter int          AW          = 16,
    parameter logic [14:0] BLANK_COLOR = 15'h7FFF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         lcd_on_i,
    input  logic [1:0]   lcd_mode_i,
    input  logic         disp_vsync_i,
    lcd_fb_if.master     fb,
    output logic         rd_bank_o,
    output logic         frame_done_o,
    output logic [7:0]   tear_cnt_o,
    output logic         ovf_o
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int PW   = $clog2(NPIX + 1);

    typedef enum logic [1:0] {S_CLEAR, S_OFF, S_ACTIVE, S_VBLANK} state_e;

    state_e        state_q;
    logic [PW-1:0] ptr_q;
    logic          wr_bank_q, rd_bank_q, pending_q;
    logic          wr_en_q, frame_done_q, ovf_q;
    logic [AW-1:0] wr_addr_q;
    logic [14:0]   wr_data_q;
    logic [7:0]    tear_q;

    logic          running, in_active, pix_ok, vsync_swap, forced_swap, swap;
    logic          bank_d, frame_full;
    logic [PW-1:0] ptr_inc, cnt_d;

    function automatic logic [AW-1:0] fb_addr(input logic bank, input logic [PW-1:0] p);
        return AW'(p) + (bank ? AW'(NPIX) : AW'(0));
    endfunction

    assign running     = lcd_on_i && (state_q == S_ACTIVE || state_q == S_VBLANK);
    assign in_active   = lcd_on_i && (state_q == S_ACTIVE);
    assign pix_ok      = in_active && fb.pix_valid && (ptr_q != PW'(NPIX));
    assign vsync_swap  = running && pending_q && disp_vsync_i;
    // first pixel of a new frame while the finished one was never shown: tear it over
    assign forced_swap = in_active && pending_q && fb.pix_valid && (ptr_q == '0) && !disp_vsync_i;
    assign swap        = vsync_swap || forced_swap;
    assign bank_d      = swap ? ~wr_bank_q : wr_bank_q;
    assign ptr_inc     = ptr_q + PW'(1);
    assign cnt_d       = pix_ok ? ptr_inc : ptr_q;
    assign frame_full  = (cnt_d == PW'(NPIX));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_CLEAR;
            ptr_q        <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b1;
            pending_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            tear_q       <= '0;
            ovf_q        <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_CLEAR: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= fb_addr(wr_bank_q, ptr_q);
                    wr_data_q <= BLANK_COLOR;
                    if (ptr_q == PW'(NPIX - 1)) begin
                        rd_bank_q <= wr_bank_q;
                        wr_bank_q <= ~wr_bank_q;
                        pending_q <= 1'b0;
                        ptr_q     <= '0;
                        state_q   <= lcd_on_i ? S_ACTIVE : S_OFF;
                    end else begin
                        ptr_q <= ptr_inc;
                    end
                end
                S_OFF: begin
                    if (lcd_on_i) begin
                        state_q <= S_ACTIVE;
                        ptr_q   <= '0;
                    end
                end
                S_ACTIVE, S_VBLANK: begin
                    if (!lcd_on_i) begin
                        state_q <= S_CLEAR;
                        ptr_q   <= '0;
                    end else begin
                        if (swap) begin
                            rd_bank_q <= wr_bank_q;
                            wr_bank_q <= ~wr_bank_q;
                            pending_q <= 1'b0;
                            if (forced_swap && tear_q != 8'hFF)
                                tear_q <= tear_q + 8'd1;
                        end
                        if (state_q == S_ACTIVE) begin
                            if (pix_ok) begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= fb_addr(bank_d, ptr_q);
                                wr_data_q <= fb.pix_data;
                                ptr_q     <= ptr_inc;
                            end else if (fb.pix_valid) begin
                                ovf_q <= 1'b1;
                            end
                            if (lcd_mode_i == 2'd1) begin
                                state_q <= S_VBLANK;
                                ptr_q   <= '0;
                                if (frame_full) begin
                                    frame_done_q <= 1'b1;
                                    pending_q    <= 1'b1;
                                end
                            end
                        end else if (lcd_mode_i != 2'd1) begin
                            state_q <= S_ACTIVE;
                        end
                    end
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    assign fb.wr_en     = wr_en_q;
    assign fb.wr_addr   = wr_addr_q;
    assign fb.wr_data   = wr_data_q;
    assign rd_bank_o    = rd_bank_q;
    assign frame_done_o = frame_done_q;
    assign tear_cnt_o   = tear_q;
    assign ovf_o        = ovf_q;
endmodule

// File: tb/tb_lcd_fb_ctrl.sv
// tb/tb_lcd_fb_ctrl.sv - scoreboard bench for lcd_fb_ctrl on a reduced 8x4 frame
module tb_lcd_fb_ctrl;
    localparam int WIDTH  = 8;
    localparam int HEIGHT = 4;
    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int AW     = 16;
    localparam logic [14:0] BLANK = 15'h7FFF;

    logic       clk = 1'b0;
    logic       reset;
    logic       lcd_on;
    logic [1:0] lcd_mode;
    logic       disp_vsync;
    logic       rd_bank;
    logic       frame_done;
    logic [7:0] tear_cnt;
    logic       ovf;

    lcd_fb_if #(.AW(AW)) fb ();

    lcd_fb_ctrl #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW), .BLANK_COLOR(BLANK)) dut (
        .clk          (clk),
        .reset        (reset),
        .lcd_on_i     (lcd_on),
        .lcd_mode_i   (lcd_mode),
        .disp_vsync_i (disp_vsync),
        .fb           (fb),
        .rd_bank_o    (rd_bank),
        .frame_done_o (frame_done),
        .tear_cnt_o   (tear_cnt),
        .ovf_o        (ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0;
    logic [30:0] exp_q[$];

    int   m_ptr;
    logic m_wr_bank, m_rd_bank, m_pending, m_ovf;
    int   m_tear;
    int   pix_seq = 0;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (fb.wr_en === 1'b1) begin
            logic [30:0] e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected: got addr=%h data=%h, required no write", fb.wr_addr, fb.wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({fb.wr_addr, fb.wr_data} !== e) begin
                    bad++;
                    $display("FAIL write_value: got addr=%h data=%h, required addr=%h data=%h",
                             fb.wr_addr, fb.wr_data, e[30:15], e[14:0]);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 4 * NPIX && exp_q.size() != 0; k++) step();
        step();
        step();
    endtask

    function automatic logic [15:0] maddr(input logic bank, input int p);
        return 16'(p + (bank ? NPIX : 0));
    endfunction

    task automatic m_swap();
        m_rd_bank = m_wr_bank;
        m_wr_bank = ~m_wr_bank;
        m_pending = 1'b0;
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n; i++) begin
            logic [14:0] d;
            d = 15'(pix_seq * 37 + 5);
            pix_seq++;
            fb.pix_valid = 1'b1;
            fb.pix_data  = d;
            if (m_pending && m_ptr == 0) begin
                m_swap();
                if (m_tear < 255) m_tear++;
            end
            if (m_ptr < NPIX) begin
                exp_q.push_back({maddr(m_wr_bank, m_ptr), d});
                m_ptr++;
            end else begin
                m_ovf = 1'b1;
            end
            step();
        end
        fb.pix_valid = 1'b0;
    endtask

    task automatic vblank();
        int fd0;
        int exp_fd;
        fd0 = fd_cnt;
        exp_fd = (m_ptr == NPIX) ? 1 : 0;
        if (exp_fd == 1) m_pending = 1'b1;
        m_ptr = 0;
        lcd_mode = 2'd1;
        step();
        lcd_mode = 2'd0;
        step();
        step();
        total++;
        if (fd_cnt - fd0 !== exp_fd) begin
            bad++;
            $display("FAIL frame_done_count: got %0d pulses, required %0d", fd_cnt - fd0, exp_fd);
        end
    endtask

    task automatic vsync();
        if (m_pending) m_swap();
        disp_vsync = 1'b1;
        step();
        disp_vsync = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; lcd_on = 1'b1; lcd_mode = 2'd0; disp_vsync = 1'b0;
        fb.pix_valid = 1'b0; fb.pix_data = '0;
        step();
        step();
        total++;
        if ({rd_bank, fb.wr_en, frame_done, tear_cnt, ovf, fb.wr_addr, fb.wr_data} !== {1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 16'd0, 15'd0}) begin
            bad++;
            $display("FAIL reset_state: got rd_bank=%b wr_en=%b fd=%b tear=%0d ovf=%b addr=%h data=%h, required 1 0 0 0 0 0 0",
                     rd_bank, fb.wr_en, frame_done, tear_cnt, ovf, fb.wr_addr, fb.wr_data);
        end
        for (int i = 0; i < NPIX; i++) exp_q.push_back({maddr(1'b0, i), BLANK});
        reset = 1'b0;
        fb.pix_valid = 1'b1;
        fb.pix_data  = 15'h1234;
        for (int i = 0; i < 10; i++) step();
        fb.pix_valid = 1'b0;
        wait_drain();
        m_ptr = 0; m_wr_bank = 1'b1; m_rd_bank = 1'b0; m_pending = 1'b0; m_ovf = 1'b0; m_tear = 0;
        total++;
        if (exp_q.size() !== 0 || rd_bank !== 1'b0) begin
            bad++;
            $display("FAIL reset_clear: got left=%0d rd_bank=%b, required 0 0", exp_q.size(), rd_bank);
        end
    endtask

    task automatic test_full_frame();
        pixels(NPIX);
        vblank();
        total++;
        if (rd_bank !== 1'b0) begin
            bad++;
            $display("FAIL full_no_early_swap: got rd_bank=%b, required 0", rd_bank);
        end
        vsync();
        total++;
        if (rd_bank !== m_rd_bank || rd_bank !== 1'b1) begin
            bad++;
            $display("FAIL full_vsync_swap: got rd_bank=%b, required 1", rd_bank);
        end
        pixels(3);
        vblank();
        wait_drain();
    endtask

    task automatic test_short_frame();
        pixels(10);
        vblank();
        vsync();
        total++;
        if (rd_bank !== m_rd_bank) begin
            bad++;
            $display("FAIL short_no_swap: got rd_bank=%b, required %b", rd_bank, m_rd_bank);
        end
        pixels(2);
        vblank();
        wait_drain();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL short_drain: got %0d pending writes, required 0", exp_q.size());
        end
    endtask

    task automatic test_same_cycle();
        pixels(NPIX);
        vblank();
        m_swap();
        exp_q.push_back({maddr(m_wr_bank, 0), 15'h2AAA});
        m_ptr = 1;
        fb.pix_valid = 1'b1; fb.pix_data = 15'h2AAA; disp_vsync = 1'b1;
        step();
        fb.pix_valid = 1'b0; disp_vsync = 1'b0;
        step();
        total++;
        if (tear_cnt !== 8'(m_tear) || rd_bank !== m_rd_bank) begin
            bad++;
            $display("FAIL same_cycle_swap: got tear=%0d rd_bank=%b, required %0d %b", tear_cnt, rd_bank, m_tear, m_rd_bank);
        end
        pixels(NPIX - 1);
        vblank();
        vsync();
        wait_drain();
    endtask

    task automatic test_forced_swap();
        pixels(NPIX);
        vblank();
        pixels(1);
        step();
        total++;
        if (tear_cnt !== 8'd1 || rd_bank !== m_rd_bank) begin
            bad++;
            $display("FAIL forced_first: got tear=%0d rd_bank=%b, required 1 %b", tear_cnt, rd_bank, m_rd_bank);
        end
        for (int r = 0; r < 299; r++) begin
            pixels(NPIX - 1);
            vblank();
            pixels(1);
        end
        step();
        total++;
        if (tear_cnt !== 8'd255 || m_tear != 255) begin
            bad++;
            $display("FAIL forced_saturate: got tear=%0d, required 255", tear_cnt);
        end
        wait_drain();
        total++;
        if (exp_q.size() !== 0 || rd_bank !== m_rd_bank) begin
            bad++;
            $display("FAIL forced_drain: got left=%0d rd_bank=%b, required 0 %b", exp_q.size(), rd_bank, m_rd_bank);
        end
    endtask

    task automatic test_ovf();
        pixels(NPIX - 1);
        vblank();
        vsync();
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_idle: got ovf=%b, required 0", ovf);
        end
        pixels(NPIX + 1);
        step();
        total++;
        if (ovf !== 1'b1 || m_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set: got ovf=%b, required 1", ovf);
        end
        vblank();
        vsync();
        total++;
        if (rd_bank !== m_rd_bank) begin
            bad++;
            $display("FAIL ovf_frame_swap: got rd_bank=%b, required %b", rd_bank, m_rd_bank);
        end
        wait_drain();
    endtask

    task automatic test_lcd_off();
        pixels(5);
        lcd_on = 1'b0;
        fb.pix_valid = 1'b1;
        fb.pix_data  = 15'h0F0F;
        for (int i = 0; i < NPIX; i++) exp_q.push_back({maddr(m_wr_bank, i), BLANK});
        m_swap();
        m_ptr = 0;
        wait_drain();
        for (int i = 0; i < 5; i++) step();
        fb.pix_valid = 1'b0;
        total++;
        if (exp_q.size() !== 0 || rd_bank !== m_rd_bank) begin
            bad++;
            $display("FAIL off_clear: got left=%0d rd_bank=%b, required 0 %b", exp_q.size(), rd_bank, m_rd_bank);
        end
        total++;
        if (ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky: got ovf=%b, required 1", ovf);
        end
        lcd_on = 1'b1;
        step();
        pixels(2);
        wait_drain();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL on_again: got %0d pending writes, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_same_cycle();
        test_forced_swap();
        test_ovf();
        test_lcd_off();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
